// File: rtl/cpu_pipe_pkg.sv
// Shared pipeline constants: EX operand forward selects, stall-cause encodings
// and the default register-address width.
package cpu_pipe_pkg;

    localparam int RA_W_DEF = 5;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    localparam logic [1:0] CAUSE_NONE = 2'b00;
    localparam logic [1:0] CAUSE_LOAD = 2'b01;
    localparam logic [1:0] CAUSE_LONG = 2'b10;
    localparam logic [1:0] CAUSE_BOTH = 2'b11;

endpackage

// File: rtl/long_op_scoreboard.sv
// Fixed-latency long-op tracker: one countdown slot per outstanding mul/div,
// in-order single completion per cycle, sticky overflow on issue into a full board.
module long_op_scoreboard
    import cpu_pipe_pkg::*;
#(
    parameter int RA_W     = RA_W_DEF,
    parameter int LONG_LAT = 4,
    parameter int SB_DEPTH = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                long_issue,
    input  logic [RA_W-1:0]     long_dst,
    input  logic [RA_W-1:0]     id_rs,
    input  logic [RA_W-1:0]     id_rt,
    output logic [SB_DEPTH-1:0] rs_match,
    output logic [SB_DEPTH-1:0] rt_match,
    output logic                long_full,
    output logic                long_wb_valid,
    output logic [RA_W-1:0]     long_wb_dst,
    output logic                sb_overflow
);

    localparam int CNT_W = $clog2(LONG_LAT);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LONG_LAT - 1);

    logic [SB_DEPTH-1:0] valid_q, valid_d;
    logic [RA_W-1:0]     dst_q [SB_DEPTH];
    logic [RA_W-1:0]     dst_d [SB_DEPTH];
    logic [CNT_W-1:0]    rem_q [SB_DEPTH];
    logic [CNT_W-1:0]    rem_d [SB_DEPTH];
    logic                sb_overflow_q, sb_overflow_d;

    logic [SB_DEPTH-1:0] done;
    logic [SB_DEPTH-1:0] slot_free;
    logic                alloc_ok;

    // A slot completing this cycle counts as free, so a full board still accepts an issue.
    for (genvar gi = 0; gi < SB_DEPTH; gi++) begin : g_slot
        assign done[gi]      = valid_q[gi] && (rem_q[gi] == '0);
        assign slot_free[gi] = !valid_q[gi] || done[gi];
        assign rs_match[gi]  = valid_q[gi] && (dst_q[gi] == id_rs);
        assign rt_match[gi]  = valid_q[gi] && (dst_q[gi] == id_rt);
    end

    assign long_full     = &valid_q;
    assign long_wb_valid = |done;
    assign sb_overflow   = sb_overflow_q;

    always_comb begin
        long_wb_dst = '0;
        for (int i = 0; i < SB_DEPTH; i++) begin
            if (done[i]) begin
                long_wb_dst = long_wb_dst | dst_q[i];
            end
        end
    end

    always_comb begin
        valid_d       = valid_q;
        dst_d         = dst_q;
        rem_d         = rem_q;
        sb_overflow_d = sb_overflow_q;
        alloc_ok      = 1'b0;
        for (int i = 0; i < SB_DEPTH; i++) begin
            if (done[i]) begin
                valid_d[i] = 1'b0;
            end else if (valid_q[i]) begin
                rem_d[i] = rem_q[i] - 1'b1;
            end
        end
        if (long_issue) begin
            for (int i = 0; i < SB_DEPTH; i++) begin
                if (!alloc_ok && slot_free[i]) begin
                    valid_d[i] = 1'b1;
                    dst_d[i]   = long_dst;
                    rem_d[i]   = CNT_INIT;
                    alloc_ok   = 1'b1;
                end
            end
            if (!alloc_ok) begin
                sb_overflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q       <= '0;
            sb_overflow_q <= 1'b0;
            for (int i = 0; i < SB_DEPTH; i++) begin
                dst_q[i] <= '0;
                rem_q[i] <= '0;
            end
        end else begin
            valid_q       <= valid_d;
            sb_overflow_q <= sb_overflow_d;
            for (int i = 0; i < SB_DEPTH; i++) begin
                dst_q[i] <= dst_d[i];
                rem_q[i] <= rem_d[i];
            end
        end
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// EX operand forwarding, load-use and long-op hazard detection, decode stall
// generation and a saturating stalled-cycle counter.
module fwd_hazard_unit
    import cpu_pipe_pkg::*;
#(
    parameter int RA_W     = RA_W_DEF,
    parameter int LONG_LAT = 4,
    parameter int SB_DEPTH = 2,
    parameter int PERF_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [RA_W-1:0]   id_rs,
    input  logic [RA_W-1:0]   id_rt,
    input  logic [RA_W-1:0]   ex_rs,
    input  logic [RA_W-1:0]   ex_rt,
    input  logic              ex_regwrite,
    input  logic              ex_memread,
    input  logic [RA_W-1:0]   ex_dst,
    input  logic              mem_regwrite,
    input  logic [RA_W-1:0]   mem_dst,
    input  logic              wb_regwrite,
    input  logic [RA_W-1:0]   wb_dst,
    input  logic              long_issue,
    input  logic [RA_W-1:0]   long_dst,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic              stall_if_id,
    output logic              flush_id_ex,
    output logic              long_full,
    output logic              long_wb_valid,
    output logic [RA_W-1:0]   long_wb_dst,
    output logic              sb_overflow,
    output logic [1:0]        stall_cause,
    output logic [PERF_W-1:0] perf_stall_cnt
);

    logic [SB_DEPTH-1:0] rs_match, rt_match;
    logic                load_use, long_haz, stall;
    logic                rs_long, rt_long;
    logic [1:0]          stall_cause_q, stall_cause_d;
    logic [PERF_W-1:0]   perf_stall_cnt_q, perf_stall_cnt_d;

    long_op_scoreboard #(
        .RA_W     (RA_W),
        .LONG_LAT (LONG_LAT),
        .SB_DEPTH (SB_DEPTH)
    ) u_sb (
        .clk           (clk),
        .rst           (rst),
        .long_issue    (long_issue),
        .long_dst      (long_dst),
        .id_rs         (id_rs),
        .id_rt         (id_rt),
        .rs_match      (rs_match),
        .rt_match      (rt_match),
        .long_full     (long_full),
        .long_wb_valid (long_wb_valid),
        .long_wb_dst   (long_wb_dst),
        .sb_overflow   (sb_overflow)
    );

    // EX/M result is younger than M/WB, so it wins when both match.
    always_comb begin
        fwd_a = FWD_RF;
        if (mem_regwrite && (mem_dst != '0) && (mem_dst == ex_rs)) begin
            fwd_a = FWD_MEM;
        end else if (wb_regwrite && (wb_dst != '0) && (wb_dst == ex_rs)) begin
            fwd_a = FWD_WB;
        end
    end

    always_comb begin
        fwd_b = FWD_RF;
        if (mem_regwrite && (mem_dst != '0) && (mem_dst == ex_rt)) begin
            fwd_b = FWD_MEM;
        end else if (wb_regwrite && (wb_dst != '0) && (wb_dst == ex_rt)) begin
            fwd_b = FWD_WB;
        end
    end

    assign load_use = ex_memread && ex_regwrite && (ex_dst != '0)
                   && ((ex_dst == id_rs) || (ex_dst == id_rt));

    // An op leaving EX this cycle is not in the scoreboard yet but must already block its consumer.
    assign rs_long  = (id_rs != '0) && ((|rs_match) || (long_issue && (long_dst == id_rs)));
    assign rt_long  = (id_rt != '0) && ((|rt_match) || (long_issue && (long_dst == id_rt)));
    assign long_haz = rs_long || rt_long;

    assign stall       = load_use || long_haz;
    assign stall_if_id = stall;
    assign flush_id_ex = stall;

    always_comb begin
        stall_cause_d = CAUSE_NONE;
        if (load_use && long_haz) begin
            stall_cause_d = CAUSE_BOTH;
        end else if (long_haz) begin
            stall_cause_d = CAUSE_LONG;
        end else if (load_use) begin
            stall_cause_d = CAUSE_LOAD;
        end
    end

    always_comb begin
        perf_stall_cnt_d = perf_stall_cnt_q;
        if (stall && (perf_stall_cnt_q != '1)) begin
            perf_stall_cnt_d = perf_stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cause_q    <= CAUSE_NONE;
            perf_stall_cnt_q <= '0;
        end else begin
            stall_cause_q    <= stall_cause_d;
            perf_stall_cnt_q <= perf_stall_cnt_d;
        end
    end

    assign stall_cause    = stall_cause_q;
    assign perf_stall_cnt = perf_stall_cnt_q;

endmodule
